vid_frame_src: RTL and testbench
================================

// Module: vid_frame_src
// PURPOSE
//  Frame-stream transmitter for the VIP pipeline. Reads one stored RGB888 frame from a
//  synchronous-read pixel RAM and emits it as a vsync/href/valid pixel stream. This is the
//  stream format consumed by the RGB->YCbCr->HistEQ->RGB chain.
//  Sits between frame-buffer memory and the first pipeline stage; also serves as the TB stimulus source.
// PARAMETERS
//  H_ACTIVE  800     active pixels per line
//  V_ACTIVE  600     active lines per frame (H_ACTIVE*V_ACTIVE = 480000 = IMG_TOTAL)
//  H_BLANK   160     blank cycles after each line (href low)
//  VSYNC_W   2       vsync pulse width, in lines (line = H_ACTIVE+H_BLANK cycles)
//  V_BP      4       back-porch lines, vsync low, no href
//  V_FP      2       front-porch lines after last active line
//  RD_LAT    2       RAM read latency, cycles (>=1)
//  ADDR_W    19      RAM address width
// PORTS
//  clk          in   1       pixel clock
//  rst_n        in   1       reset, asynchronous, active-low
//  start        in   1       one-cycle frame request
//  continuous   in   1       1 = auto-restart next frame after front porch
//  busy         out  1       frame in progress (any state but IDLE)
//  frame_done   out  1       one-cycle pulse on the last front-porch cycle
//  mem_rd_en    out  1       RAM read strobe
//  mem_rd_addr  out  ADDR_W  pixel address, raster order
//  mem_rd_data  in   24      {R,G,B}; valid RD_LAT cycles after mem_rd_en
//  post_vsync   out  1       frame sync, active high
//  post_href    out  1       line-active
//  post_valid   out  1       pixel valid (== post_href; kept separate for the pipeline port)
//  post_r/g/b   out  8 each  pixel data; 0 when post_valid=0
// BEHAVIOUR
//  - Reset: all outputs 0; FSM=IDLE; h_cnt, v_cnt and addr = 0. Reset is async: a mid-frame
//    rst_n drops the stream immediately, and no frame_done is issued.
//  - FSM: IDLE -> VSYNC (VSYNC_W lines) -> VBP (V_BP lines) -> ACTIVE (V_ACTIVE lines) -> VFP (V_FP lines)
//    - Leaving VFP: go to VSYNC if continuous=1, else IDLE. continuous is sampled on the last VFP cycle.
//    - IDLE->VSYNC on start=1. start while busy is ignored; it is not queued.
//  - Line timing: h_cnt counts 0..H_ACTIVE+H_BLANK-1 and wraps. v_cnt increments on each h_cnt wrap.
//    v_cnt resets to 0 on every state change.
//  - Raw timing:
//    - vs_raw=1 in VSYNC.
//    - hr_raw=1 in ACTIVE when h_cnt<H_ACTIVE; mem_rd_en=hr_raw.
//  - Address: mem_rd_addr = current pixel index. It increments after each read and is cleared in VSYNC.
//    Width is ADDR_W; no wrap occurs within a frame (max H_ACTIVE*V_ACTIVE-1).
//  - Alignment: vs_raw/hr_raw pass through an RD_LAT-stage shift register, then one output register.
//    post_* fire RD_LAT+1 cycles after the corresponding raw cycle, with mem_rd_data registered in the same
//    cycle, so pixel N appears with the Nth post_valid. Fixed latency start->first post_vsync = RD_LAT+2 cycles.
//  - busy=1 from the cycle after start is accepted until the cycle after frame_done.
//    Pipeline tail drains during the first cycles of IDLE: post_* for VFP are already 0, so nothing is lost.
//  - Per frame: exactly H_ACTIVE*V_ACTIVE valid pixels; href pulses of exactly H_ACTIVE cycles;
//    V_ACTIVE pulses; the gap between pulses is exactly H_BLANK.
// CONFIGURATION
//  VID_FRAME_SRC_TESTPAT_EN
//  - Defined: extra input test_pat (1 bit) is sampled at VSYNC entry and held for the whole frame.
//    When latched 1: mem_rd_en stays 0 and output is 8 vertical colour bars, each H_ACTIVE/8 wide,
//    order white, yellow, cyan, green, magenta, red, blue, black (components 255/0). Timing and latency
//    are identical to RAM mode.
//  - Undefined: test_pat port is absent; output always comes from RAM.
// TESTING (H_ACTIVE=8, V_ACTIVE=4, H_BLANK=4, VSYNC_W=1, V_BP=1, V_FP=1, RD_LAT=2; RAM[i]={i,~i,i})
//  1. start pulse, continuous=0:
//     - post_vsync high 12 cycles, first one 4 cycles after start.
//     - 4 href pulses of 8 cycles with 4-cycle gaps.
//     - 32 valid pixels with R=0..31, G=~R.
//     - frame_done once; then busy=0.
//  2. continuous=1 across 2 frames: second VSYNC follows the VFP end with no gap; addr restarts at 0;
//     64 total valid pixels. continuous=0 during frame 2 -> stops after frame 2.
//  3. start re-pulsed mid ACTIVE -> ignored; frame still exactly 32 pixels; one frame_done.
//  4. rst_n low at pixel 13 for 3 cycles -> all outputs 0 the same cycle; no frame_done.
//     A later start gives a clean frame beginning at addr 0.
//  5. RD_LAT=1 rebuild: pixel-to-data alignment holds (R==index on every valid); first vsync 3 cycles after start.
//  6. [TESTPAT_EN] test_pat=1: mem_rd_en never 1; line pixels = 255,255,255 ... 0,0,0 (one per bar, width 1).

Source files
------------

// File: rtl/vid_frame_src.sv
// vid_frame_src: stored RGB888 frame to vsync/href/valid stream transmitter.
// Build option VID_FRAME_SRC_TESTPAT_EN adds a test_pat input (8 colour bars).
`timescale 1ns/1ps

module vid_frame_src #(
  parameter int H_ACTIVE = 800,
  parameter int V_ACTIVE = 600,
  parameter int H_BLANK  = 160,
  parameter int VSYNC_W  = 2,
  parameter int V_BP     = 4,
  parameter int V_FP     = 2,
  parameter int RD_LAT   = 2,
  parameter int ADDR_W   = 19
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              continuous,
`ifdef VID_FRAME_SRC_TESTPAT_EN
  input  logic              test_pat,
`endif
  output logic              busy,
  output logic              frame_done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [23:0]       mem_rd_data,
  output logic              post_vsync,
  output logic              post_href,
  output logic              post_valid,
  output logic [7:0]        post_r,
  output logic [7:0]        post_g,
  output logic [7:0]        post_b
);

  localparam int H_TOT = H_ACTIVE + H_BLANK;
  localparam int HW    = (H_TOT > 1) ? $clog2(H_TOT) : 1;
  localparam int M1    = (VSYNC_W > V_BP) ? VSYNC_W : V_BP;
  localparam int M2    = (V_ACTIVE > V_FP) ? V_ACTIVE : V_FP;
  localparam int V_MAX = (M1 > M2) ? M1 : M2;
  localparam int VW    = (V_MAX > 1) ? $clog2(V_MAX) : 1;

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
  localparam logic [HW-1:0] H_ACT   = HW'(H_ACTIVE);
  localparam logic [VW-1:0] VS_LAST = VW'(VSYNC_W - 1);
  localparam logic [VW-1:0] BP_LAST = VW'(V_BP - 1);
  localparam logic [VW-1:0] AC_LAST = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] FP_LAST = VW'(V_FP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_VSYNC,
    S_VBP,
    S_ACT,
    S_VFP
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [HW-1:0]       h_cnt;
  logic [VW-1:0]       v_cnt;
  logic [VW-1:0]       v_last;
  logic                h_wrap;
  logic                st_end;
  logic                vs_raw;
  logic                hr_raw;
  logic [ADDR_W-1:0]   addr;
  logic [RD_LAT-1:0]   vs_d;
  logic [RD_LAT-1:0]   hr_d;
  logic [23:0]         px;

  assign h_wrap      = (h_cnt == H_LAST);
  assign st_end      = h_wrap && (v_cnt == v_last);
  assign busy        = (state != S_IDLE);
  assign mem_rd_addr = addr;

  // Number of lines spent in the current state, minus one.
  always_comb begin
    v_last = '0;
    unique case (state)
      S_VSYNC: v_last = VS_LAST;
      S_VBP:   v_last = BP_LAST;
      S_ACT:   v_last = AC_LAST;
      S_VFP:   v_last = FP_LAST;
      default: v_last = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next state and raw timing strobes.
  always_comb begin
    state_nx   = state;
    vs_raw     = 1'b0;
    hr_raw     = 1'b0;
    frame_done = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) state_nx = S_VSYNC;
      end
      S_VSYNC: begin
        vs_raw = 1'b1;
        if (st_end) state_nx = S_VBP;
      end
      S_VBP: begin
        if (st_end) state_nx = S_ACT;
      end
      S_ACT: begin
        hr_raw = (h_cnt < H_ACT);
        if (st_end) state_nx = S_VFP;
      end
      S_VFP: begin
        frame_done = st_end;
        if (st_end) state_nx = continuous ? S_VSYNC : S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Pixel and line counters; line count restarts with each state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (state == S_IDLE) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_wrap ? '0 : h_cnt + 1'b1;
      if (state_nx != state) v_cnt <= '0;
      else if (h_wrap)       v_cnt <= v_cnt + 1'b1;
    end
  end

  // Raster read address, rewound at the start of every frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 addr <= '0;
    else if (state == S_VSYNC)  addr <= '0;
    else if (hr_raw)            addr <= addr + 1'b1;
  end

  // Delay sync strobes to line up with the RAM read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d <= '0;
      hr_d <= '0;
    end else begin
      vs_d[0] <= vs_raw;
      hr_d[0] <= hr_raw;
      for (int i = 1; i < RD_LAT; i++) begin
        vs_d[i] <= vs_d[i-1];
        hr_d[i] <= hr_d[i-1];
      end
    end
  end

`ifdef VID_FRAME_SRC_TESTPAT_EN
  localparam int BAR_W = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;

  logic       pat_q;
  logic [2:0] bar_idx;
  logic [2:0] bar_rgb;
  logic [3:0] pd [RD_LAT];

  assign mem_rd_en = hr_raw & ~pat_q;
  assign bar_rgb   = {~bar_idx[1], ~bar_idx[2], ~bar_idx[0]};

  // Pattern select is frozen for the whole frame at VSYNC entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pat_q <= 1'b0;
    else if (state_nx == S_VSYNC && state != S_VSYNC)
      pat_q <= test_pat;
  end

  // Bar number: count of bar boundaries already passed on this line.
  always_comb begin
    bar_idx = '0;
    for (int k = 1; k < 8; k++) begin
      if (h_cnt >= HW'(k * BAR_W)) bar_idx = 3'(k);
    end
  end

  // Carry pattern mode and bar colour alongside the sync strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < RD_LAT; i++) pd[i] <= '0;
    end else begin
      pd[0] <= {pat_q, bar_rgb};
      for (int i = 1; i < RD_LAT; i++) pd[i] <= pd[i-1];
    end
  end

  // Pixel source: colour bars or RAM data.
  always_comb begin
    px = mem_rd_data;
    if (pd[RD_LAT-1][3])
      px = {{8{pd[RD_LAT-1][2]}},
            {8{pd[RD_LAT-1][1]}},
            {8{pd[RD_LAT-1][0]}}};
  end
`else
  assign mem_rd_en = hr_raw;

  // Pixel source: RAM data only.
  always_comb begin
    px = mem_rd_data;
  end
`endif

  // Output register; pixel data forced to zero outside href.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_vsync <= 1'b0;
      post_href  <= 1'b0;
      post_valid <= 1'b0;
      post_r     <= '0;
      post_g     <= '0;
      post_b     <= '0;
    end else begin
      post_vsync <= vs_d[RD_LAT-1];
      post_href  <= hr_d[RD_LAT-1];
      post_valid <= hr_d[RD_LAT-1];
      if (hr_d[RD_LAT-1]) begin
        post_r <= px[23:16];
        post_g <= px[15:8];
        post_b <= px[7:0];
      end else begin
        post_r <= '0;
        post_g <= '0;
        post_b <= '0;
      end
    end
  end

endmodule

// File: tb/tb_vid_frame_src.sv
// tb_vid_frame_src: randomized checks of vid_frame_src against a
// closed-form raster timing model, with RD_LAT=2 and RD_LAT=1 instances.
`timescale 1ns/1ps

module tb_vid_frame_src;

  localparam int H    = 8;
  localparam int V    = 4;
  localparam int HB   = 4;
  localparam int VSW  = 1;
  localparam int BP   = 1;
  localparam int FP   = 1;
  localparam int AW   = 8;
  localparam int LT   = H + HB;
  localparam int F    = (VSW + BP + V + FP) * LT;
  localparam int NPIX = H * V;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start0 = 1'b0;
  logic start1 = 1'b0;
  logic cont0 = 1'b0;
  logic cont1 = 1'b0;
`ifdef VID_FRAME_SRC_TESTPAT_EN
  logic pat0 = 1'b0;
  logic pat1 = 1'b0;
`endif

  logic          busy0, fd0, rd0, vs0, hr0, va0;
  logic [AW-1:0] a0;
  logic [23:0]   d0;
  logic [7:0]    r0, g0, b0;
  logic          busy1, fd1, rd1, vs1, hr1, va1;
  logic [AW-1:0] a1;
  logic [23:0]   d1;
  logic [7:0]    r1, g1, b1;

  logic [23:0] ram [NPIX];
  logic [23:0] bars [8];
  logic [23:0] q0a, q0b, q1a;

  int cyc = 0;
  int n_vec = 0;
  int n_err = 0;
  int m0_k = 0, m0_n = 0, m1_k = 0, m1_n = 0;
  bit m0_on = 0, m0_pat = 0, m1_on = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM models: latency 2 for dut0, latency 1 for dut1.
  always @(posedge clk) begin
    q0a <= rd0 ? ram[a0[4:0]] : 24'h5A5A5A;
    q0b <= q0a;
    q1a <= rd1 ? ram[a1[4:0]] : 24'h5A5A5A;
  end
  assign d0 = q0b;
  assign d1 = q1a;

  vid_frame_src #(
    .H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .VSYNC_W(VSW),
    .V_BP(BP), .V_FP(FP), .RD_LAT(2), .ADDR_W(AW)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .continuous(cont0),
`ifdef VID_FRAME_SRC_TESTPAT_EN
    .test_pat(pat0),
`endif
    .busy(busy0), .frame_done(fd0), .mem_rd_en(rd0),
    .mem_rd_addr(a0), .mem_rd_data(d0),
    .post_vsync(vs0), .post_href(hr0), .post_valid(va0),
    .post_r(r0), .post_g(g0), .post_b(b0)
  );

  vid_frame_src #(
    .H_ACTIVE(H), .V_ACTIVE(V), .H_BLANK(HB), .VSYNC_W(VSW),
    .V_BP(BP), .V_FP(FP), .RD_LAT(1), .ADDR_W(AW)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .continuous(cont1),
`ifdef VID_FRAME_SRC_TESTPAT_EN
    .test_pat(pat1),
`endif
    .busy(busy1), .frame_done(fd1), .mem_rd_en(rd1),
    .mem_rd_addr(a1), .mem_rd_data(d1),
    .post_vsync(vs1), .post_href(hr1), .post_valid(va1),
    .post_r(r1), .post_g(g1), .post_b(b1)
  );

  function automatic logic [39:0] act0();
    return {busy0, fd0, rd0, rd0 ? a0 : 8'h00, vs0, hr0, va0,
            2'b00, r0, g0, b0};
  endfunction

  function automatic logic [39:0] act1();
    return {busy1, fd1, rd1, rd1 ? a1 : 8'h00, vs1, hr1, va1,
            2'b00, r1, g1, b1};
  endfunction

  // Expected outputs at cycle c for nfr chained frames started at
  // cycle k: raw raster position is c-k-1, outputs lag by lat+1.
  function automatic logic [39:0] exp_vec(int c, int lat, int k,
                                          int nfr, bit on, bit pat);
    logic [39:0] v;
    int r, q, pos, ln, col, ai;
    v = '0;
    if (!on) return v;
    r = c - k - 1;
    if (r >= 0 && r < nfr * F) begin
      pos = r % F;
      ln  = pos / LT;
      col = pos % LT;
      v[39] = 1'b1;
      v[38] = (pos == F - 1);
      if (!pat && ln >= VSW + BP && ln < VSW + BP + V && col < H) begin
        v[37]    = 1'b1;
        v[36:29] = 8'((ln - VSW - BP) * H + col);
      end
    end
    q = r - lat - 1;
    if (q >= 0 && q < nfr * F) begin
      pos = q % F;
      ln  = pos / LT;
      col = pos % LT;
      v[28] = (ln < VSW);
      if (ln >= VSW + BP && ln < VSW + BP + V && col < H) begin
        ai    = (ln - VSW - BP) * H + col;
        v[27] = 1'b1;
        v[26] = 1'b1;
        v[23:0] = pat ? bars[col / (H / 8)] : ram[ai];
      end
    end
    return v;
  endfunction

  task automatic go0(output int k);
    @(posedge clk);
    #1 start0 = 1'b1;
    k = cyc;
    @(posedge clk);
    #1 start0 = 1'b0;
  endtask

  task automatic rand_ram();
    for (int i = 0; i < NPIX; i++) ram[i] = 24'($urandom);
  endtask

  task automatic test_reset();
    logic [39:0] ev;
    m0_on = 0;
    m1_on = 0;
    rst_n = 1'b0;
    start0 = 1'b1;
    repeat (3) begin
      @(negedge clk);
      ev = exp_vec(cyc, 2, 0, 0, 0, 0);
      n_vec++;
      if (act0() !== ev || act1() !== ev) begin
        n_err++;
        $display("FAIL reset_state got=%h/%h want=%h", act0(), act1(), ev);
      end
    end
    start0 = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      n_vec++;
      if (act0() !== 40'h0) begin
        n_err++;
        $display("FAIL idle_after_reset got=%h want=0", act0());
      end
    end
  endtask

  task automatic test_single();
    int k, vs_n = 0, val_n = 0, fd_n = 0, pulses = 0;
    int first_vs = -1, bad_pix = 0;
    logic prev = 1'b0;
    logic [39:0] ev, av;
    for (int i = 0; i < NPIX; i++) ram[i] = {8'(i), ~8'(i), 8'(i)};
    cont0 = 1'b0;
    m0_pat = 0;
    repeat ($urandom_range(1, 5)) @(posedge clk);
    go0(k);
    m0_k = k; m0_n = 1; m0_on = 1;
    repeat (F + 10) begin
      @(negedge clk);
      ev = exp_vec(cyc, 2, m0_k, m0_n, m0_on, m0_pat);
      av = act0();
      n_vec++;
      if (av !== ev) begin
        n_err++;
        $display("FAIL single_cycle t=%0d got=%h want=%h", cyc - k, av, ev);
      end
      if (vs0 && first_vs < 0) first_vs = cyc - k;
      vs_n += int'(vs0);
      fd_n += int'(fd0);
      if (hr0 && !prev) pulses++;
      prev = hr0;
      if (va0) begin
        if (r0 != 8'(val_n) || g0 != ~r0) bad_pix++;
        val_n++;
      end
    end
    n_vec += 7;
    if (first_vs != 4) begin
      n_err++; $display("FAIL first_vsync got=%0d want=4", first_vs);
    end
    if (vs_n != VSW * LT) begin
      n_err++; $display("FAIL vsync_len got=%0d want=%0d", vs_n, VSW * LT);
    end
    if (pulses != V) begin
      n_err++; $display("FAIL href_pulses got=%0d want=%0d", pulses, V);
    end
    if (val_n != NPIX) begin
      n_err++; $display("FAIL pixel_count got=%0d want=%0d", val_n, NPIX);
    end
    if (bad_pix != 0) begin
      n_err++; $display("FAIL pixel_order got=%0d bad want=0", bad_pix);
    end
    if (fd_n != 1) begin
      n_err++; $display("FAIL frame_done got=%0d want=1", fd_n);
    end
    if (busy0 !== 1'b0) begin
      n_err++; $display("FAIL busy_end got=%b want=0", busy0);
    end
  endtask

  task automatic test_continuous();
    int k, val_n = 0, fd_n = 0, busy_n = 0, vs_n = 0;
    logic [39:0] ev, av;
    rand_ram();
    cont0 = 1'b1;
    go0(k);
    m0_k = k; m0_n = 2; m0_on = 1;
    repeat (2 * F + 10) begin
      @(negedge clk);
      if (cyc - k == F + 20) cont0 = 1'b0;
      ev = exp_vec(cyc, 2, m0_k, m0_n, m0_on, m0_pat);
      av = act0();
      n_vec++;
      if (av !== ev) begin
        n_err++;
        $display("FAIL cont_cycle t=%0d got=%h want=%h", cyc - k, av, ev);
      end
      val_n  += int'(va0);
      fd_n   += int'(fd0);
      busy_n += int'(busy0);
      vs_n   += int'(vs0);
    end
    n_vec += 4;
    if (val_n != 2 * NPIX) begin
      n_err++; $display("FAIL cont_pixels got=%0d want=%0d", val_n, 2 * NPIX);
    end
    if (fd_n != 2) begin
      n_err++; $display("FAIL cont_done got=%0d want=2", fd_n);
    end
    if (busy_n != 2 * F) begin
      n_err++; $display("FAIL cont_busy got=%0d want=%0d", busy_n, 2 * F);
    end
    if (vs_n != 2 * VSW * LT) begin
      n_err++; $display("FAIL cont_vsync got=%0d want=%0d", vs_n, 2 * VSW * LT);
    end
  endtask

  task automatic test_restart_ignored();
    int k, x, val_n = 0, fd_n = 0;
    logic [39:0] ev, av;
    rand_ram();
    cont0 = 1'b0;
    go0(k);
    m0_k = k; m0_n = 1; m0_on = 1;
    x = $urandom_range(1 + 2 * LT, (2 + V) * LT);
    repeat (F + 10) begin
      @(negedge clk);
      start0 = (cyc - k == x) || (cyc - k == F);
      ev = exp_vec(cyc, 2, m0_k, m0_n, m0_on, m0_pat);
      av = act0();
      n_vec++;
      if (av !== ev) begin
        n_err++;
        $display("FAIL restart_cycle t=%0d got=%h want=%h", cyc - k, av, ev);
      end
      val_n += int'(va0);
      fd_n  += int'(fd0);
    end
    start0 = 1'b0;
    n_vec += 2;
    if (val_n != NPIX) begin
      n_err++; $display("FAIL restart_pixels got=%0d want=%0d", val_n, NPIX);
    end
    if (fd_n != 1) begin
      n_err++; $display("FAIL restart_done got=%0d want=1", fd_n);
    end
  endtask

  task automatic test_back_to_back();
    int k, val_n = 0, fd_n = 0;
    logic [39:0] ev, av;
    rand_ram();
    go0(k);
    m0_k = k; m0_n = 1; m0_on = 1;
    repeat (F) @(negedge clk);
    go0(k);
    m0_k = k;
    repeat (F + 10) begin
      @(negedge clk);
      ev = exp_vec(cyc, 2, m0_k, m0_n, m0_on, m0_pat);
      av = act0();
      n_vec++;
      if (av !== ev) begin
        n_err++;
        $display("FAIL b2b_cycle t=%0d got=%h want=%h", cyc - k, av, ev);
      end
      val_n += int'(va0);
      fd_n  += int'(fd0);
    end
    n_vec += 2;
    if (val_n != NPIX) begin
      n_err++; $display("FAIL b2b_pixels got=%0d want=%0d", val_n, NPIX);
    end
    if (fd_n != 1) begin
      n_err++; $display("FAIL b2b_done got=%0d want=1", fd_n);
    end
  endtask

  task automatic test_async_reset();
    int k, fd_n = 0, val_n = 0, first_addr = -1;
    logic [39:0] ev, av;
    rand_ram();
    go0(k);
    m0_k = k; m0_n = 1; m0_on = 1;
    repeat (1 + (2 + 1) * LT + 5 - 1) begin
      @(negedge clk);
      ev = exp_vec(cyc, 2, m0_k, m0_n, m0_on, m0_pat);
      av = act0();
      n_vec++;
      if (av !== ev) begin
        n_err++;
        $display("FAIL prereset_cycle t=%0d got=%h want=%h", cyc - k, av, ev);
      end
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    m0_on = 0;
    repeat (3) begin
      @(negedge clk);
      n_vec++;
      if (act0() !== 40'h0) begin
        n_err++;
        $display("FAIL reset_drop t=%0d got=%h want=0", cyc - k, act0());
      end
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (F + 10) begin
      @(negedge clk);
      fd_n += int'(fd0);
      n_vec++;
      if (act0() !== 40'h0) begin
        n_err++;
        $display("FAIL post_reset_idle got=%h want=0", act0());
      end
    end
    n_vec++;
    if (fd_n != 0) begin
      n_err++; $display("FAIL reset_no_done got=%0d want=0", fd_n);
    end
    go0(k);
    m0_k = k; m0_on = 1;
    repeat (F + 10) begin
      @(negedge clk);
      ev = exp_vec(cyc, 2, m0_k, m0_n, m0_on, m0_pat);
      av = act0();
      n_vec++;
      if (av !== ev) begin
        n_err++;
        $display("FAIL clean_cycle t=%0d got=%h want=%h", cyc - k, av, ev);
      end
      if (rd0 && first_addr < 0) first_addr = int'(a0);
      val_n += int'(va0);
    end
    n_vec += 2;
    if (first_addr != 0) begin
      n_err++; $display("FAIL clean_addr got=%0d want=0", first_addr);
    end
    if (val_n != NPIX) begin
      n_err++; $display("FAIL clean_pixels got=%0d want=%0d", val_n, NPIX);
    end
  endtask

  task automatic test_rdlat1();
    int k, val_n = 0, first_vs = -1, bad_pix = 0;
    logic [39:0] ev, av;
    for (int i = 0; i < NPIX; i++) ram[i] = {8'(i), ~8'(i), 8'(i)};
    @(posedge clk);
    #1 start1 = 1'b1;
    k = cyc;
    @(posedge clk);
    #1 start1 = 1'b0;
    m1_k = k; m1_n = 1; m1_on = 1;
    repeat (F + 10) begin
      @(negedge clk);
      ev = exp_vec(cyc, 1, m1_k, m1_n, m1_on, 0);
      av = act1();
      n_vec++;
      if (av !== ev) begin
        n_err++;
        $display("FAIL lat1_cycle t=%0d got=%h want=%h", cyc - k, av, ev);
      end
      if (vs1 && first_vs < 0) first_vs = cyc - k;
      if (va1) begin
        if (r1 != 8'(val_n)) bad_pix++;
        val_n++;
      end
    end
    n_vec += 3;
    if (first_vs != 3) begin
      n_err++; $display("FAIL lat1_first_vsync got=%0d want=3", first_vs);
    end
    if (val_n != NPIX) begin
      n_err++; $display("FAIL lat1_pixels got=%0d want=%0d", val_n, NPIX);
    end
    if (bad_pix != 0) begin
      n_err++; $display("FAIL lat1_align got=%0d bad want=0", bad_pix);
    end
  endtask

`ifdef VID_FRAME_SRC_TESTPAT_EN
  task automatic test_pattern();
    int k, rd_n = 0, val_n = 0, bad = 0;
    logic [39:0] ev, av;
    rand_ram();
    pat0 = 1'b1;
    go0(k);
    pat0 = 1'b0;
    m0_k = k; m0_n = 1; m0_on = 1; m0_pat = 1;
    repeat (F + 10) begin
      @(negedge clk);
      ev = exp_vec(cyc, 2, m0_k, m0_n, m0_on, m0_pat);
      av = act0();
      n_vec++;
      if (av !== ev) begin
        n_err++;
        $display("FAIL pat_cycle t=%0d got=%h want=%h", cyc - k, av, ev);
      end
      rd_n += int'(rd0);
      if (va0) begin
        if ({r0, g0, b0} != bars[val_n % 8]) bad++;
        val_n++;
      end
    end
    m0_pat = 0;
    n_vec += 2;
    if (rd_n != 0) begin
      n_err++; $display("FAIL pat_rd_en got=%0d want=0", rd_n);
    end
    if (bad != 0) begin
      n_err++; $display("FAIL pat_bars got=%0d bad want=0", bad);
    end
  endtask
`endif

  initial begin
    bars[0] = 24'hFFFFFF;
    bars[1] = 24'hFFFF00;
    bars[2] = 24'h00FFFF;
    bars[3] = 24'h00FF00;
    bars[4] = 24'hFF00FF;
    bars[5] = 24'hFF0000;
    bars[6] = 24'h0000FF;
    bars[7] = 24'h000000;
    test_reset();
    test_single();
    test_continuous();
    test_restart_ignored();
    test_back_to_back();
    test_async_reset();
    test_rdlat1();
`ifdef VID_FRAME_SRC_TESTPAT_EN
    test_pattern();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
